fp_to_int: RTL and testbench

FP_TO_INT -- requirements
Module: fp_to_int

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fp_to_int.sv | 148 ++++++++++++++
 tb/tb_fp_to_int.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand field layout, exponent bias, status bit
// positions and the state encoding of the float-to-integer converter.
package fpu_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 7;
  localparam int MANT_W   = 24;
  localparam int EXP_BIAS = 63;

  // Exponent at which the mantissa LSB carries weight 2^0 (86).
  localparam int INT_POINT  = EXP_BIAS + MANT_W - 1;
  // From here on a normalised mantissa reaches 2^31 and cannot fit.
  localparam int OVF_EXP    = INT_POINT + 8;
  // One step past the mantissa width already leaves only the sticky bit.
  localparam int MAX_RSHIFT = MANT_W + 1;

  localparam int ST_ZERO      = 3;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 1;
  localparam int ST_INEXACT   = 0;

  typedef enum logic [1:0] {
    F2I_IDLE,
    F2I_UNPACK,
    F2I_SHIFT,
    F2I_PACK
  } f2i_state_e;

endpackage

// File: rtl/fp_to_int.sv
// Serial float-to-integer converter: truncates an FPU-format operand toward
// zero using a one-bit-per-cycle shifter, with saturation and status flags.
module fp_to_int
  import fpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_in,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic        done,
  output logic        busy
);

  f2i_state_e  state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  k_q, k_d;
  logic        left_q, left_d;
  logic        sticky_q, sticky_d;
  logic        ovf_q, ovf_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  status_q, status_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic              sign_w;
  logic [EXP_W-1:0]  exp_w;
  logic [MANT_W-1:0] mant_w;
  logic [EXP_W-1:0]  rdist;
  logic [31:0]       res;

  assign sign_w = op_q[EXP_W+MANT_W +: SIGN_W];
  assign exp_w  = op_q[MANT_W +: EXP_W];
  assign mant_w = op_q[0 +: MANT_W];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_d    = mag_q;
    k_d      = k_q;
    left_d   = left_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    data_d   = data_q;
    status_d = status_q;
    done_d   = 1'b0;
    rdist    = EXP_W'(INT_POINT) - exp_w;
    res      = '0;

    case (state_q)
      F2I_IDLE: begin
        if (start) begin
          op_d    = op_in;
          state_d = F2I_UNPACK;
        end
      end

      F2I_UNPACK: begin
        mag_d    = {{(32-MANT_W){1'b0}}, mant_w};
        sticky_d = 1'b0;
        ovf_d    = 1'b0;
        left_d   = 1'b1;
        k_d      = '0;
        if (mant_w == '0) begin
          k_d = '0;
        end else if (exp_w >= EXP_W'(OVF_EXP)) begin
          ovf_d = 1'b1;
        end else if (exp_w >= EXP_W'(INT_POINT)) begin
          k_d = 5'(exp_w - EXP_W'(INT_POINT));
        end else begin
          left_d = 1'b0;
          k_d    = (rdist > EXP_W'(MAX_RSHIFT)) ? 5'(MAX_RSHIFT) : rdist[4:0];
        end
        state_d = F2I_SHIFT;
      end

      F2I_SHIFT: begin
        if (k_q == '0) begin
          state_d = F2I_PACK;
        end else begin
          k_d = k_q - 5'd1;
          if (left_q) begin
            mag_d = {mag_q[30:0], 1'b0};
          end else begin
            mag_d    = {1'b0, mag_q[31:1]};
            sticky_d = sticky_q | mag_q[0];
          end
        end
      end

      F2I_PACK: begin
        if (ovf_q) begin
          res = sign_w ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
          res = sign_w ? (~mag_q + 32'd1) : mag_q;
        end
        status_d               = '0;
        status_d[ST_ZERO]      = (res == '0);
        status_d[ST_OVERFLOW]  = ovf_q;
        status_d[ST_UNDERFLOW] = (mant_w != '0) && (res == '0);
        status_d[ST_INEXACT]   = sticky_q;
        data_d  = res;
        done_d  = 1'b1;
        state_d = F2I_IDLE;
      end

      default: state_d = F2I_IDLE;
    endcase

    busy_d = (state_d != F2I_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= F2I_IDLE;
      op_q     <= '0;
      mag_q    <= '0;
      k_q      <= '0;
      left_q   <= 1'b0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_q    <= mag_d;
      k_q      <= k_d;
      left_q   <= left_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      status_q <= status_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign status_out = status_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Directed bench for fp_to_int: hand-computed conversions, latency, pulse
// behaviour, start held high and reset during an operation.
module tb_fp_to_int;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] op_in;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fp_to_int dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op_in      (op_in),
    .data_out   (data_out),
    .status_out (status_out),
    .done       (done),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Start is sampled on the posedge; op_in is scrambled right after capture.
  task automatic launch(input logic [31:0] op);
    @(negedge clock);
    op_in = op;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op_in = ~op;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [31:0] op,
                                input logic [31:0] exp_data, input logic [3:0] exp_status,
                                input int exp_lat);
    int lat;
    launch(op);
    check_output({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(lat);
    check_output({tag, "_lat"}, lat, exp_lat);
    check_output({tag, "_data"}, data_out, exp_data);
    check_output({tag, "_status"}, {28'd0, status_out}, {28'd0, exp_status});
  endtask

  initial begin
    int lat;
    int n_done;
    int first_at;
    int second_at;

    start = 1'b0;
    op_in = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst_data",   data_out,              32'd0);
    check_output("rst_status", {28'd0, status_out},   32'd0);
    check_output("rst_done",   {31'd0, done},         32'd0);
    check_output("rst_busy",   {31'd0, busy},         32'd0);
    @(negedge clock);
    reset = 1'b1;

    apply_stimulus("two",      32'h4080_0000, 32'h0000_0002, 4'b0000, 25);
    @(posedge clock);
    #1;
    check_output("done_pulse", {31'd0, done}, 32'd0);
    check_output("data_hold",  data_out,      32'h0000_0002);

    apply_stimulus("m2p5",     32'hC0A0_0000, 32'hFFFF_FFFE, 4'b0001, 25);
    apply_stimulus("one_p5",   32'h3FC0_0000, 32'h0000_0001, 4'b0001, 26);
    apply_stimulus("pow30",    32'h5D80_0000, 32'h4000_0000, 4'b0000, 10);
    apply_stimulus("ovf_pos",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0100, 3);
    apply_stimulus("ovf_neg",  32'hFFFF_FFFF, 32'h8000_0000, 4'b0100, 3);
    apply_stimulus("pow31",    32'h5E80_0000, 32'h7FFF_FFFF, 4'b0100, 3);
    apply_stimulus("mpow31",   32'hDE80_0000, 32'h8000_0000, 4'b0100, 3);
    apply_stimulus("unf",      32'h0100_0001, 32'h0000_0000, 4'b1011, 28);
    apply_stimulus("zero",     32'h0000_0000, 32'h0000_0000, 4'b1000, 3);
    apply_stimulus("neg_zero", 32'hFF00_0000, 32'h0000_0000, 4'b1000, 3);

    // Start held high: each done is followed by an accept one cycle later.
    @(negedge clock);
    op_in = 32'h4080_0000;
    start = 1'b1;
    @(posedge clock);
    n_done    = 0;
    first_at  = 0;
    second_at = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clock);
      #1;
      if (done) begin
        n_done++;
        if (n_done == 1) first_at = cyc;
        if (n_done == 2) second_at = cyc;
        check_output("held_data", data_out, 32'h0000_0002);
      end
    end
    check_output("held_count",  n_done,               32'd3);
    check_output("held_first",  first_at,             32'd25);
    check_output("held_period", second_at - first_at, 32'd26);
    start = 1'b0;
    wait_done(lat);
    check_output("held_tail", {31'd0, done}, 32'd1);

    // Reset in the middle of a long right shift, then a clean conversion.
    launch(32'h0100_0001);
    repeat (10) @(posedge clock);
    #1;
    check_output("mid_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check_output("mid_rst_data",   data_out,            32'd0);
    check_output("mid_rst_status", {28'd0, status_out}, 32'd0);
    check_output("mid_rst_busy",   {31'd0, busy},       32'd0);
    check_output("mid_rst_done",   {31'd0, done},       32'd0);
    @(negedge clock);
    reset = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) n_done++;
    end
    check_output("mid_rst_nodone", n_done,   32'd0);
    check_output("mid_rst_keep",   data_out, 32'd0);
    apply_stimulus("after_rst", 32'h3FC0_0000, 32'h0000_0001, 4'b0001, 26);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
